// File: rtl/lc3b_branch_ctrl_if.sv
// Handshake and bus signals between decode/datapath and the LC-3b branch controller.
// The master side is decode/datapath; the slave side is lc3b_branch_ctrl.
interface lc3b_branch_ctrl_if;
  logic        cc_load;
  logic [15:0] cc_word;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_nzp;
  logic [15:0] br_target;
  logic        flush;
  logic        resp_valid;
  logic        resp_taken;
  logic        pc_load;
  logic [15:0] pc_target;
  logic [2:0]  cc_nzp;

  modport master (
    output cc_load, cc_word, br_valid, br_nzp, br_target, flush,
    input  br_ready, resp_valid, resp_taken, pc_load, pc_target, cc_nzp
  );

  modport slave (
    input  cc_load, cc_word, br_valid, br_nzp, br_target, flush,
    output br_ready, resp_valid, resp_taken, pc_load, pc_target, cc_nzp
  );
endinterface

// File: rtl/lc3b_branch_ctrl.sv
// LC-3b branch controller: owns the NZP condition codes and resolves branches against them.
// Optional taken/not-taken statistics counters are enabled by defining LC3B_BR_STATS_EN.
module lc3b_branch_ctrl #(
  parameter int CC_LAT = 1
`ifdef LC3B_BR_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  lc3b_branch_ctrl_if.slave bus
`ifdef LC3B_BR_STATS_EN
  , input  logic              stats_clr
  , output logic [STAT_W-1:0] taken_cnt
  , output logic [STAT_W-1:0] nottaken_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_CC, EVAL, RESP} state_t;

  function automatic logic [2:0] classify(input logic [15:0] w);
    logic n;
    logic z;
    n = w[15];
    z = (w == 16'h0000);
    return {n, z, (!n && !z)};
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  cc_q, cc_d;
  logic [2:0]  nzp_q, nzp_d;
  logic [15:0] target_q, target_d;
  logic        taken_q, taken_d;

  logic        commit_vld;
  logic [2:0]  commit_cc;
  logic        pipe_busy;
  logic        cc_pending;

  logic        br_ready;
  logic        resp_valid;
  logic        resp_taken;
  logic        pc_load;

  // CC_LAT=1 commits straight from the input; deeper latencies add CC_LAT-1 valid-tagged stages.
  if (CC_LAT == 1) begin : g_no_pipe
    assign commit_vld = bus.cc_load;
    assign commit_cc  = classify(bus.cc_word);
    assign pipe_busy  = 1'b0;
  end else begin : g_pipe
    localparam int PD = CC_LAT - 1;

    logic [PD-1:0]      pipe_vld_q, pipe_vld_d;
    logic [PD-1:0][2:0] pipe_cc_q, pipe_cc_d;

    always_comb begin
      pipe_vld_d    = pipe_vld_q;
      pipe_cc_d     = pipe_cc_q;
      pipe_vld_d[0] = bus.cc_load;
      pipe_cc_d[0]  = classify(bus.cc_word);
      for (int i = 1; i < PD; i++) begin
        pipe_vld_d[i] = pipe_vld_q[i-1];
        pipe_cc_d[i]  = pipe_cc_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pipe_vld_q <= '0;
        pipe_cc_q  <= '0;
      end else begin
        pipe_vld_q <= pipe_vld_d;
        pipe_cc_q  <= pipe_cc_d;
      end
    end

    assign commit_vld = pipe_vld_q[PD-1];
    assign commit_cc  = pipe_cc_q[PD-1];
    assign pipe_busy  = |pipe_vld_q;
  end

  assign cc_pending = bus.cc_load | pipe_busy;

  always_comb begin
    cc_d = cc_q;
    if (commit_vld) cc_d = commit_cc;
  end

  always_comb begin
    state_d    = state_q;
    nzp_d      = nzp_q;
    target_d   = target_q;
    taken_d    = taken_q;
    br_ready   = 1'b0;
    resp_valid = 1'b0;
    resp_taken = 1'b0;
    pc_load    = 1'b0;

    case (state_q)
      IDLE: begin
        br_ready = !bus.flush;
        if (bus.br_valid && !bus.flush) begin
          nzp_d    = bus.br_nzp;
          target_d = bus.br_target;
          // Unconditional and never-taken masks do not depend on CC, so skip the hazard wait.
          if (bus.br_nzp == 3'b111 || bus.br_nzp == 3'b000) begin
            state_d = EVAL;
          end else if (cc_pending) begin
            state_d = WAIT_CC;
          end else begin
            state_d = EVAL;
          end
        end
      end
      WAIT_CC: begin
        if (!cc_pending) state_d = EVAL;
      end
      EVAL: begin
        taken_d = |(nzp_q & cc_q);
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_taken = taken_q;
        pc_load    = taken_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cc_q     <= 3'b010;
      nzp_q    <= 3'b000;
      target_q <= 16'h0000;
      taken_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cc_q     <= cc_d;
      nzp_q    <= nzp_d;
      target_q <= target_d;
      taken_q  <= taken_d;
    end
  end

  assign bus.br_ready   = br_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_taken = resp_taken;
  assign bus.pc_load    = pc_load;
  assign bus.pc_target  = target_q;
  assign bus.cc_nzp     = cc_q;

`ifdef LC3B_BR_STATS_EN
  logic [STAT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [STAT_W-1:0] nottaken_cnt_q, nottaken_cnt_d;

  // Clear takes priority over a same-cycle resolution; counters stick at all-ones.
  always_comb begin
    taken_cnt_d    = taken_cnt_q;
    nottaken_cnt_d = nottaken_cnt_q;
    if (stats_clr) begin
      taken_cnt_d    = '0;
      nottaken_cnt_d = '0;
    end else if (resp_valid) begin
      if (resp_taken) begin
        if (!(&taken_cnt_q)) taken_cnt_d = taken_cnt_q + 1'b1;
      end else begin
        if (!(&nottaken_cnt_q)) nottaken_cnt_d = nottaken_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
    end else begin
      taken_cnt_q    <= taken_cnt_d;
      nottaken_cnt_q <= nottaken_cnt_d;
    end
  end

  assign taken_cnt    = taken_cnt_q;
  assign nottaken_cnt = nottaken_cnt_q;
`endif

  a_cc_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot(cc_q));
  a_pc_load:   assert property (@(posedge clk) disable iff (!reset_n) pc_load == (resp_valid & resp_taken));

endmodule

// File: tb/tb_lc3b_branch_ctrl.sv
// Directed self-checking bench for lc3b_branch_ctrl: one instance with CC_LAT=1, one with CC_LAT=3.
// Defining LC3B_BR_STATS_EN also exercises the statistics counters with STAT_W=2.
module tb_lc3b_branch_ctrl;

  logic clk;
  logic reset_n;
  int   errCount   = 0;
  int   checkCount = 0;
  logic sawResp;

  lc3b_branch_ctrl_if bus1 ();
  lc3b_branch_ctrl_if bus3 ();

`ifdef LC3B_BR_STATS_EN
  logic       statsClr;
  logic [1:0] takenCnt;
  logic [1:0] nottakenCnt;

  lc3b_branch_ctrl #(.CC_LAT(1), .STAT_W(2)) u_dut1 (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus1),
    .stats_clr    (statsClr),
    .taken_cnt    (takenCnt),
    .nottaken_cnt (nottakenCnt)
  );

  lc3b_branch_ctrl #(.CC_LAT(3), .STAT_W(2)) u_dut3 (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus3),
    .stats_clr    (1'b0),
    .taken_cnt    (),
    .nottaken_cnt ()
  );
`else
  lc3b_branch_ctrl #(.CC_LAT(1)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  lc3b_branch_ctrl #(.CC_LAT(3)) u_dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus3)
  );
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Starts a new cycle: waits past the edge, idles both buses, then drives the selected one.
  task automatic applyStimulus(input int sel, input logic load, input logic [15:0] word,
                               input logic valid, input logic [2:0] nzp,
                               input logic [15:0] target, input logic fl);
    @(posedge clk);
    #1;
    bus1.cc_load = 1'b0; bus1.cc_word = 16'h0; bus1.br_valid = 1'b0;
    bus1.br_nzp = 3'b0; bus1.br_target = 16'h0; bus1.flush = 1'b0;
    bus3.cc_load = 1'b0; bus3.cc_word = 16'h0; bus3.br_valid = 1'b0;
    bus3.br_nzp = 3'b0; bus3.br_target = 16'h0; bus3.flush = 1'b0;
    if (sel == 1) begin
      bus1.cc_load = load; bus1.cc_word = word; bus1.br_valid = valid;
      bus1.br_nzp = nzp; bus1.br_target = target; bus1.flush = fl;
    end else begin
      bus3.cc_load = load; bus3.cc_word = word; bus3.br_valid = valid;
      bus3.br_nzp = nzp; bus3.br_target = target; bus3.flush = fl;
    end
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1, 1'b0, 16'h0, 1'b0, 3'b000, 16'h0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    bus1.cc_load = 1'b0; bus1.cc_word = 16'h0; bus1.br_valid = 1'b0;
    bus1.br_nzp = 3'b0; bus1.br_target = 16'h0; bus1.flush = 1'b0;
    bus3.cc_load = 1'b0; bus3.cc_word = 16'h0; bus3.br_valid = 1'b0;
    bus3.br_nzp = 3'b0; bus3.br_target = 16'h0; bus3.flush = 1'b0;
`ifdef LC3B_BR_STATS_EN
    statsClr = 1'b0;
`endif
    #22;
    reset_n = 1'b1;
    #1;

    // Reset state
    checkOutput("rst_cc",      {29'b0, bus1.cc_nzp}, 32'h2);
    checkOutput("rst_ready",   {31'b0, bus1.br_ready}, 32'h1);
    checkOutput("rst_resp",    {31'b0, bus1.resp_valid}, 32'h0);
    checkOutput("rst_pc_tgt",  {16'b0, bus1.pc_target}, 32'h0);
    checkOutput("rst_cc3",     {29'b0, bus3.cc_nzp}, 32'h2);

    // CC classification with CC_LAT=1
    applyStimulus(1, 1'b1, 16'h8000, 1'b0, 3'b000, 16'h0, 1'b0);
    idleCycle();
    checkOutput("cc_neg", {29'b0, bus1.cc_nzp}, 32'h4);
    applyStimulus(1, 1'b1, 16'h0001, 1'b0, 3'b000, 16'h0, 1'b0);
    idleCycle();
    checkOutput("cc_pos", {29'b0, bus1.cc_nzp}, 32'h1);

    // No-hazard taken branch: accept cycle 0, response cycle 2, ready again cycle 3
    applyStimulus(1, 1'b0, 16'h0, 1'b1, 3'b001, 16'h3000, 1'b0);
    checkOutput("br_accept_rdy", {31'b0, bus1.br_ready}, 32'h1);
    idleCycle();
    checkOutput("br_c1_rdy",  {31'b0, bus1.br_ready}, 32'h0);
    checkOutput("br_c1_resp", {31'b0, bus1.resp_valid}, 32'h0);
    idleCycle();
    checkOutput("br_c2_resp",  {31'b0, bus1.resp_valid}, 32'h1);
    checkOutput("br_c2_taken", {31'b0, bus1.resp_taken}, 32'h1);
    checkOutput("br_c2_pcld",  {31'b0, bus1.pc_load}, 32'h1);
    checkOutput("br_c2_tgt",   {16'b0, bus1.pc_target}, 32'h3000);
    idleCycle();
    checkOutput("br_c3_rdy",  {31'b0, bus1.br_ready}, 32'h1);
    checkOutput("br_c3_resp", {31'b0, bus1.resp_valid}, 32'h0);

    // nzp=000 with a concurrent cc_load: no hazard wait, never taken
    applyStimulus(1, 1'b1, 16'h0005, 1'b1, 3'b000, 16'h4000, 1'b0);
    idleCycle();
    checkOutput("nop_c1_resp", {31'b0, bus1.resp_valid}, 32'h0);
    idleCycle();
    checkOutput("nop_c2_resp",  {31'b0, bus1.resp_valid}, 32'h1);
    checkOutput("nop_c2_taken", {31'b0, bus1.resp_taken}, 32'h0);
    checkOutput("nop_c2_pcld",  {31'b0, bus1.pc_load}, 32'h0);
    checkOutput("nop_c2_tgt",   {16'b0, bus1.pc_target}, 32'h4000);

    // nzp=111 with a concurrent cc_load: same timing, always taken
    applyStimulus(1, 1'b1, 16'hFFFF, 1'b1, 3'b111, 16'h4400, 1'b0);
    idleCycle();
    checkOutput("all_c1_resp", {31'b0, bus1.resp_valid}, 32'h0);
    idleCycle();
    checkOutput("all_c2_resp",  {31'b0, bus1.resp_valid}, 32'h1);
    checkOutput("all_c2_taken", {31'b0, bus1.resp_taken}, 32'h1);
    checkOutput("all_c2_pcld",  {31'b0, bus1.pc_load}, 32'h1);
    checkOutput("all_c2_tgt",   {16'b0, bus1.pc_target}, 32'h4400);
    checkOutput("all_cc",       {29'b0, bus1.cc_nzp}, 32'h4);

    // Hazard with CC_LAT=1, plus a younger cc_load during EVAL that must not affect the result
    applyStimulus(1, 1'b1, 16'h0000, 1'b1, 3'b100, 16'h4800, 1'b0);
    checkOutput("hz_c0_rdy", {31'b0, bus1.br_ready}, 32'h1);
    idleCycle();
    checkOutput("hz_c1_cc",   {29'b0, bus1.cc_nzp}, 32'h2);
    checkOutput("hz_c1_resp", {31'b0, bus1.resp_valid}, 32'h0);
    applyStimulus(1, 1'b1, 16'h8000, 1'b0, 3'b000, 16'h0, 1'b0);
    checkOutput("hz_c2_resp", {31'b0, bus1.resp_valid}, 32'h0);
    idleCycle();
    checkOutput("hz_c3_resp",  {31'b0, bus1.resp_valid}, 32'h1);
    checkOutput("hz_c3_taken", {31'b0, bus1.resp_taken}, 32'h0);
    checkOutput("hz_c3_cc",    {29'b0, bus1.cc_nzp}, 32'h4);
    idleCycle();
    checkOutput("hz_c4_rdy", {31'b0, bus1.br_ready}, 32'h1);

    // CC_LAT=3: a load in cycle k is visible from cycle k+3
    applyStimulus(3, 1'b1, 16'hFFFF, 1'b0, 3'b000, 16'h0, 1'b0);
    idleCycle();
    idleCycle();
    checkOutput("lat3_c2_cc", {29'b0, bus3.cc_nzp}, 32'h2);
    idleCycle();
    checkOutput("lat3_c3_cc", {29'b0, bus3.cc_nzp}, 32'h4);

    // CC_LAT=3 hazard: load zero in cycle 0, branch on z in cycle 1, response in cycle 5
    applyStimulus(3, 1'b1, 16'h0000, 1'b0, 3'b000, 16'h0, 1'b0);
    applyStimulus(3, 1'b0, 16'h0, 1'b1, 3'b010, 16'h5000, 1'b0);
    checkOutput("l3hz_c1_rdy", {31'b0, bus3.br_ready}, 32'h1);
    idleCycle();
    checkOutput("l3hz_c2_rdy", {31'b0, bus3.br_ready}, 32'h0);
    checkOutput("l3hz_c2_cc",  {29'b0, bus3.cc_nzp}, 32'h4);
    idleCycle();
    checkOutput("l3hz_c3_cc",   {29'b0, bus3.cc_nzp}, 32'h2);
    checkOutput("l3hz_c3_resp", {31'b0, bus3.resp_valid}, 32'h0);
    idleCycle();
    checkOutput("l3hz_c4_resp", {31'b0, bus3.resp_valid}, 32'h0);
    idleCycle();
    checkOutput("l3hz_c5_resp",  {31'b0, bus3.resp_valid}, 32'h1);
    checkOutput("l3hz_c5_taken", {31'b0, bus3.resp_taken}, 32'h1);
    checkOutput("l3hz_c5_pcld",  {31'b0, bus3.pc_load}, 32'h1);
    checkOutput("l3hz_c5_tgt",   {16'b0, bus3.pc_target}, 32'h5000);

    // Flush while waiting on CC: back to IDLE, no response ever, CC pipe still commits
    applyStimulus(3, 1'b1, 16'h0001, 1'b0, 3'b000, 16'h0, 1'b0);
    applyStimulus(3, 1'b0, 16'h0, 1'b1, 3'b001, 16'h5400, 1'b0);
    applyStimulus(3, 1'b0, 16'h0, 1'b0, 3'b000, 16'h0, 1'b1);
    checkOutput("fl_wait_rdy", {31'b0, bus3.br_ready}, 32'h0);
    idleCycle();
    checkOutput("fl_idle_rdy", {31'b0, bus3.br_ready}, 32'h1);
    sawResp = bus3.resp_valid;
    for (int i = 0; i < 6; i++) begin
      idleCycle();
      sawResp = sawResp | bus3.resp_valid;
    end
    checkOutput("fl_no_resp", {31'b0, sawResp}, 32'h0);
    checkOutput("fl_cc",      {29'b0, bus3.cc_nzp}, 32'h1);

    // Flush in IDLE blocks acceptance
    applyStimulus(3, 1'b0, 16'h0, 1'b1, 3'b111, 16'h5800, 1'b1);
    checkOutput("fli_rdy", {31'b0, bus3.br_ready}, 32'h0);
    idleCycle();
    checkOutput("fli_next_rdy", {31'b0, bus3.br_ready}, 32'h1);
    idleCycle();
    checkOutput("fli_no_resp", {31'b0, bus3.resp_valid}, 32'h0);

`ifdef LC3B_BR_STATS_EN
    // Saturating counters with STAT_W=2, then clear colliding with a resolution
    idleCycle();
    statsClr = 1'b1;
    idleCycle();
    statsClr = 1'b0;
    checkOutput("st_clr_taken", {30'b0, takenCnt}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1'b0, 16'h0, 1'b1, 3'b111, 16'h6000, 1'b0);
      idleCycle();
      idleCycle();
    end
    idleCycle();
    checkOutput("st_taken_sat", {30'b0, takenCnt}, 32'h3);
    checkOutput("st_nottaken",  {30'b0, nottakenCnt}, 32'h0);
    applyStimulus(1, 1'b0, 16'h0, 1'b1, 3'b000, 16'h6400, 1'b0);
    idleCycle();
    idleCycle();
    statsClr = 1'b1;
    checkOutput("st_clr_resp", {31'b0, bus1.resp_valid}, 32'h1);
    idleCycle();
    statsClr = 1'b0;
    checkOutput("st_clr_nt",    {30'b0, nottakenCnt}, 32'h0);
    checkOutput("st_clr_taken2", {30'b0, takenCnt}, 32'h0);
`endif

    // Reset mid-branch: state returns at once and the aborted branch never responds
    applyStimulus(1, 1'b0, 16'h0, 1'b1, 3'b111, 16'h7000, 1'b0);
    idleCycle();
    reset_n = 1'b0;
    #1;
    checkOutput("mr_resp", {31'b0, bus1.resp_valid}, 32'h0);
    checkOutput("mr_rdy",  {31'b0, bus1.br_ready}, 32'h1);
    checkOutput("mr_cc",   {29'b0, bus1.cc_nzp}, 32'h2);
    checkOutput("mr_tgt",  {16'b0, bus1.pc_target}, 32'h0);
    idleCycle();
    checkOutput("mr_hold_resp", {31'b0, bus1.resp_valid}, 32'h0);
    reset_n = 1'b1;
    idleCycle();
    checkOutput("mr_after_resp", {31'b0, bus1.resp_valid}, 32'h0);
    checkOutput("mr_after_rdy",  {31'b0, bus1.br_ready}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/lc3b_branch_ctrl.md
Name: lc3b_branch_ctrl

Overview:
- Sequences LC-3b conditional-branch resolution against the architectural NZP condition-code register.
- Owns the CC register and classifies each result word written back by the datapath.
- Accepts branch requests from decode over a valid/ready handshake and stalls them until all pending CC writes have landed.
- Evaluates the request's nzp mask against CC, then drives PC redirect and a one-cycle response to control.

Parameters:
- CC_LAT, 1, cycles from cc_load to the CC register update; legal range 1..4.
- STAT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cc_load  in  1  result word valid for CC update this cycle.
- cc_word  in  16  result word (lc3b_word).
- br_valid  in  1  branch request valid.
- br_ready  out  1  controller can accept a request.
- br_nzp  in  3  instruction mask {n,z,p}.
- br_target  in  16  branch target address.
- flush  in  1  cancel any in-flight branch.
- resp_valid  out  1  one-cycle pulse: branch resolved.
- resp_taken  out  1  resolution result; meaningful only when resp_valid=1.
- pc_load  out  1  load PC this cycle; equals resp_valid & resp_taken.
- pc_target  out  16  redirect address; held from the latched br_target.
- cc_nzp  out  3  current architectural CC {n,z,p}.

Behaviour:
- Reset (async assert, sync release):
  - CC = 3'b010.
  - CC pipeline cleared.
  - FSM in IDLE.
  - br_ready=1 (subject to flush); resp_valid, resp_taken, pc_load = 0; pc_target = 16'h0000.
- CC classification of a word w: n=w[15]; z=(w==16'h0000); p=!n&&!z. Exactly one bit is set.
- CC pipeline:
  - The classified result enters a CC_LAT-deep valid-tagged shift pipe.
  - CC is written on the edge ending cycle k+CC_LAT-1, where k is the cycle cc_load was high.
  - cc_pending = cc_load | any pipe stage valid.
  - Back-to-back loads commit in order; the last one wins.
- FSM states: IDLE, WAIT_CC, EVAL, RESP.
  - IDLE: br_ready = !flush. Accept when br_valid && br_ready; latch br_nzp and br_target on acceptance.
    - br_nzp==3'b111 or 3'b000: go to EVAL; no hazard check needed.
    - Otherwise: go to WAIT_CC if cc_pending in the accept cycle, else EVAL.
  - WAIT_CC: br_ready=0. Go to EVAL in the first cycle with cc_pending==0.
  - EVAL: br_ready=0. Register taken = |(latched_nzp & CC). A cc_load during EVAL belongs to a younger instruction and does not affect the result. Go to RESP.
  - RESP: resp_valid=1; resp_taken=taken; pc_load=taken; pc_target=latched target. br_ready=0. Go to IDLE.
- Latency:
  - No hazard: accept in cycle 0, resp_valid in cycle 2, br_ready high again in cycle 3.
  - Hazard: add cycles spent in WAIT_CC.
- nzp=3'b000 always resolves not-taken (LC-3b NOP). nzp=3'b111 always resolves taken.
- flush:
  - Any state goes to IDLE on the next edge.
  - A flush seen in RESP does not suppress that cycle's outputs.
  - A flush in IDLE blocks acceptance (br_ready=0).
  - The CC pipeline is not flushed.
- Reset asserted mid-operation: all state returns to reset values immediately; no resp_valid is issued for the aborted branch.
- br_valid while br_ready=0 is held by the requester; the controller ignores it.
- cc_nzp always reflects the committed CC register, never pipe contents.

Optional Feature:
- Macro: LC3B_BR_STATS_EN.
- When defined:
  - Adds ports stats_clr (in, 1), taken_cnt (out, STAT_W) and nottaken_cnt (out, STAT_W).
  - The selected counter increments on each resp_valid and saturates at all-ones.
  - stats_clr zeroes both counters; clear wins over a same-cycle increment.
  - Counters are 0 at reset.
- When undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- After reset, check cc_nzp=3'b010 and br_ready=1. Then cc_load with cc_word=16'h8000 (CC_LAT=1) -> cc_nzp=3'b100 next cycle.
- CC=3'b001, no cc_load, accept br_nzp=3'b001 with target 16'h3000 in cycle 0 -> cycle 2: resp_valid=1, resp_taken=1, pc_load=1, pc_target=16'h3000; cycle 3: br_ready=1.
- CC_LAT=3: cc_load with word 16'h0000 in cycle 0; accept br_nzp=3'b010 in cycle 1 -> controller holds in WAIT_CC until the pipe drains; CC=3'b010 at cycle 3; resp_valid at cycle 5 with taken=1.
- br_nzp=3'b000 with cc_load active -> no WAIT_CC; resp_valid in cycle 2 with taken=0, pc_load=0. br_nzp=3'b111 -> taken=1 with the same timing.
- Accept a branch, then assert flush during WAIT_CC -> IDLE next cycle, no resp_valid ever for it. flush asserted in IDLE with br_valid=1 -> not accepted.
- With LC3B_BR_STATS_EN and STAT_W=2: 5 taken branches -> taken_cnt=3 (saturated). Then stats_clr asserted in the same cycle as a resp_valid -> counter reads 0.
